padded_fm_reader: RTL and testbench

- Initiator for the padding address unit. Walks every coordinate of a padded feature map in row-major order and presents each (x, y) to the padding unit.
- Consumes the unit's realAddr/realAddrEn answer. Emits a zero word for padding locations and issues a memory read for feature-map locations.
- Produces an ordered data stream with valid/ready handshake. Sits between the padding unit, the feature-map buffer read port and the conv window/line buffer.

---
 rtl/cnn_pad_pkg.sv | 28 ++
 rtl/padded_fm_reader_if.sv | 38 +++
 rtl/padded_scan_counter.sv | 41 ++++
 rtl/padded_fm_reader.sv | 109 ++++++++++
 tb/tb_padded_fm_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pad_pkg.sv
// Shared widths, padding-unit answer encodings and scan FSM states for the
// padded feature-map reader.
package cnn_pad_pkg;

  localparam int COORD_W = 11;
  localparam int ADDR_W  = 64;
  localparam int PAD_W   = 4;

  localparam logic [1:0] EN_INVALID = 2'd0;
  localparam logic [1:0] EN_PAD     = 2'd1;
  localparam logic [1:0] EN_FM      = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    MEM,
    EMIT,
    DONE
  } state_t;

  // One extra bit so an oversize padded dimension is visible in the MSB.
  function automatic logic [COORD_W:0] padDim(input logic [PAD_W-1:0]   padA,
                                              input logic [COORD_W-1:0] fmDim,
                                              input logic [PAD_W-1:0]   padB);
    return (COORD_W+1)'(padA) + (COORD_W+1)'(fmDim) + (COORD_W+1)'(padB);
  endfunction

endpackage

// File: rtl/padded_fm_reader_if.sv
// Padding-unit request/answer, feature-map read port and output stream of the
// padded feature-map reader; master is the reader side.
interface padded_fm_reader_if
  import cnn_pad_pkg::*;
  #(parameter int DATA_WIDTH = 16);

  logic                  padInReady;
  logic [COORD_W-1:0]    padX;
  logic [COORD_W-1:0]    padY;
  logic [ADDR_W-1:0]     padRealAddr;
  logic [1:0]            padRealAddrEn;
  logic                  padOutReady;

  logic                  memRdEn;
  logic [ADDR_W-1:0]     memRdAddr;
  logic [DATA_WIDTH-1:0] memRdData;
  logic                  memRdValid;

  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataOutValid;
  logic                  dataOutReady;
  logic                  dataOutLast;

  modport master (
    output padInReady, padX, padY, memRdEn, memRdAddr,
           dataOut, dataOutValid, dataOutLast,
    input  padRealAddr, padRealAddrEn, padOutReady, memRdData, memRdValid,
           dataOutReady
  );

  modport slave (
    input  padInReady, padX, padY, memRdEn, memRdAddr,
           dataOut, dataOutValid, dataOutLast,
    output padRealAddr, padRealAddrEn, padOutReady, memRdData, memRdValid,
           dataOutReady
  );

endinterface

// File: rtl/padded_scan_counter.sv
// Row-major x/y walker over a dimW x dimH padded map; wraps back to (0,0)
// after the last coordinate so an idle reader always presents the origin.
module padded_scan_counter
  import cnn_pad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic [COORD_W:0]   dimW,
  input  logic [COORD_W:0]   dimH,
  output logic [COORD_W-1:0] posX,
  output logic [COORD_W-1:0] posY,
  output logic               last
);

  logic lastX;
  logic lastY;

  assign lastX = ({1'b0, posX} == dimW - (COORD_W+1)'(1));
  assign lastY = ({1'b0, posY} == dimH - (COORD_W+1)'(1));
  assign last  = lastX && lastY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posX <= '0;
      posY <= '0;
    end else if (clear) begin
      posX <= '0;
      posY <= '0;
    end else if (advance) begin
      if (lastX) begin
        posX <= '0;
        posY <= lastY ? '0 : posY + COORD_W'(1);
      end else begin
        posX <= posX + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/padded_fm_reader.sv
// Walks a padded feature map in row-major order, asks the padding unit about
// each coordinate and streams zero words or feature-map reads in order.
module padded_fm_reader
  import cnn_pad_pkg::*;
  #(parameter int DATA_WIDTH = 16)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] fmX,
  input  logic [COORD_W-1:0] fmY,
  input  logic [PAD_W-1:0]   paddingUp,
  input  logic [PAD_W-1:0]   paddingDown,
  input  logic [PAD_W-1:0]   paddingLeft,
  input  logic [PAD_W-1:0]   paddingRight,
  output logic               busy,
  output logic               done,
  output logic               err,
  padded_fm_reader_if.master bus
);

  state_t                state, stateNext;
  logic [COORD_W:0]      wIn, hIn, dimW, dimH;
  logic [COORD_W-1:0]    posX, posY;
  logic                  scanLast, advance, startOk;
  logic                  capture, capFm, capBad, cfgZero, cfgOver;
  logic                  errReg, rdEn;
  logic [ADDR_W-1:0]     rdAddr;
  logic [DATA_WIDTH-1:0] dataReg;

  assign wIn     = padDim(paddingLeft, fmX, paddingRight);
  assign hIn     = padDim(paddingUp, fmY, paddingDown);
  assign cfgZero = (wIn == '0) || (hIn == '0);
  assign cfgOver = wIn[COORD_W] || hIn[COORD_W];
  assign startOk = (state == IDLE) && start;

  // The padding unit may answer combinationally in the cycle REQ is entered.
  assign capture = (state == REQ) && bus.padOutReady;
  assign capFm   = capture && (bus.padRealAddrEn == EN_FM);
  assign capBad  = capture && ((bus.padRealAddrEn == EN_INVALID) ||
                               (bus.padRealAddrEn == 2'd3));

  padded_scan_counter u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (startOk),
    .advance (advance),
    .dimW    (dimW),
    .dimH    (dimH),
    .posX    (posX),
    .posY    (posY),
    .last    (scanLast)
  );

  always_comb begin
    stateNext = state;
    advance   = 1'b0;
    unique case (state)
      IDLE: if (start) stateNext = (cfgZero || cfgOver) ? DONE : REQ;
      REQ:  if (bus.padOutReady) stateNext = capFm ? MEM : EMIT;
      MEM:  if (bus.memRdValid) stateNext = EMIT;
      EMIT: if (bus.dataOutReady) begin
        advance   = 1'b1;
        stateNext = scanLast ? DONE : REQ;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dimW    <= '0;
      dimH    <= '0;
      errReg  <= 1'b0;
      rdEn    <= 1'b0;
      rdAddr  <= '0;
      dataReg <= '0;
    end else begin
      state <= stateNext;
      rdEn  <= capFm;
      if (capFm) rdAddr <= bus.padRealAddr;
      if (startOk) begin
        dimW   <= wIn;
        dimH   <= hIn;
        errReg <= cfgOver;
      end else if (capBad) begin
        errReg <= 1'b1;
      end
      // Invalid answers fall through to the padding path and emit zero.
      if (capture && !capFm) dataReg <= '0;
      else if ((state == MEM) && bus.memRdValid) dataReg <= bus.memRdData;
    end
  end

  assign bus.padInReady   = (state == REQ);
  assign bus.padX         = posX;
  assign bus.padY         = posY;
  assign bus.memRdEn      = rdEn;
  assign bus.memRdAddr    = rdAddr;
  assign bus.dataOut      = dataReg;
  assign bus.dataOutValid = (state == EMIT);
  assign bus.dataOutLast  = (state == EMIT) && scanLast;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign err              = errReg;

endmodule

// File: tb/tb_padded_fm_reader.sv
// Scoreboard bench for padded_fm_reader: combinational padding model, latency
// programmable memory responder and a stallable stream sink.
module tb_padded_fm_reader;

  typedef struct { logic [15:0] data; logic last; } expWord_t;
  typedef struct { longint addr; int x; int y; } rdReq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] fmX, fmY;
  logic [3:0]  paddingUp, paddingDown, paddingLeft, paddingRight;
  logic        busy, done, err;

  padded_fm_reader_if #(.DATA_WIDTH(16)) bus ();

  padded_fm_reader #(.DATA_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fmX          (fmX),
    .fmY          (fmY),
    .paddingUp    (paddingUp),
    .paddingDown  (paddingDown),
    .paddingLeft  (paddingLeft),
    .paddingRight (paddingRight),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int nCmp = 0, nBad = 0;
  expWord_t expQ[$];
  rdReq_t   rdQ[$];
  int cfgFmX = 0, cfgFmY = 0, cfgPu = 0, cfgPl = 0;
  bit injInv = 0;
  int memLat = 1, rdPend = 0;
  longint pendAddr = 0;
  int stallAt = -1, stallLeft = 0;
  bit stallArm = 0, hold = 0;
  logic [15:0] holdData;
  logic holdLast;
  int doneCnt, reqCnt, validCnt, wordsRecv, lastCnt, rdSeen, expWords, expReads;

  task automatic expectEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] memWord(input longint a);
    return 16'h8000 | 16'(a * 13 + 7);
  endfunction

  // Padding unit model: answers in the same cycle the request is raised.
  always_comb begin
    int  xi, yi;
    bit  inFm;
    xi = int'(bus.padX);
    yi = int'(bus.padY);
    inFm = (xi >= cfgPl) && (xi < cfgPl + cfgFmX) && (yi >= cfgPu) && (yi < cfgPu + cfgFmY);
    bus.padOutReady   = bus.padInReady;
    bus.padRealAddrEn = inFm ? 2'd2 : 2'd1;
    if (injInv && xi == 1 && yi == 1) bus.padRealAddrEn = 2'd0;
    bus.padRealAddr   = inFm ? 64'(4 + (yi - cfgPu) * cfgFmX + (xi - cfgPl)) : 64'd0;
  end

  // Memory responder; keeps counting across reset so stale data can arrive.
  always @(negedge clk) begin
    bus.memRdValid = 1'b0;
    if (rdPend > 0) begin
      rdPend--;
      if (rdPend == 0) begin
        bus.memRdValid = 1'b1;
        bus.memRdData  = memWord(pendAddr);
      end
    end
    if (bus.memRdEn) begin
      expectEq("oneOutstanding", 64'(rdPend), 64'd0);
      if (rdQ.size() == 0) expectEq("extraRead", 64'(rdQ.size()), 64'd1);
      else begin
        rdReq_t r;
        r = rdQ.pop_front();
        expectEq("rdAddr", bus.memRdAddr, 64'(r.addr));
        expectEq("rdX", 64'(bus.padX), 64'(r.x));
        expectEq("rdY", 64'(bus.padY), 64'(r.y));
      end
      rdSeen++;
      pendAddr = longint'(bus.memRdAddr);
      rdPend   = memLat;
    end
  end

  // Stream sink with optional stall and hold-stability checking.
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      bus.dataOutReady = 1'b1;
    end else begin
      if (stallArm && wordsRecv == stallAt && bus.dataOutValid) begin
        stallLeft = 10;
        stallArm  = 0;
      end
      bus.dataOutReady = (stallLeft == 0);
      if (stallLeft > 0) stallLeft--;
      if (hold) begin
        expectEq("holdValid", 64'(bus.dataOutValid), 64'd1);
        expectEq("holdData", 64'(bus.dataOut), 64'(holdData));
        expectEq("holdLast", 64'(bus.dataOutLast), 64'(holdLast));
      end
      hold = 0;
      if (bus.dataOutValid) begin
        if (bus.dataOutReady) begin
          if (expQ.size() == 0) expectEq("extraWord", 64'(expQ.size()), 64'd1);
          else begin
            expWord_t e;
            e = expQ.pop_front();
            expectEq("data", 64'(bus.dataOut), 64'(e.data));
            expectEq("last", 64'(bus.dataOutLast), 64'(e.last));
          end
          wordsRecv++;
          if (bus.dataOutLast) lastCnt++;
        end else begin
          hold     = 1;
          holdData = bus.dataOut;
          holdLast = bus.dataOutLast;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) doneCnt++;
    if (bus.padInReady) reqCnt++;
    if (bus.dataOutValid) validCnt++;
  end

  task automatic checkIdleOutputs(input string pfx);
    expectEq({pfx, "_busy"}, 64'(busy), 64'd0);
    expectEq({pfx, "_done"}, 64'(done), 64'd0);
    expectEq({pfx, "_err"}, 64'(err), 64'd0);
    expectEq({pfx, "_padInReady"}, 64'(bus.padInReady), 64'd0);
    expectEq({pfx, "_padXY"}, 64'({bus.padX, bus.padY}), 64'd0);
    expectEq({pfx, "_memRdEn"}, 64'(bus.memRdEn), 64'd0);
    expectEq({pfx, "_memRdAddr"}, bus.memRdAddr, 64'd0);
    expectEq({pfx, "_valid"}, 64'(bus.dataOutValid), 64'd0);
    expectEq({pfx, "_lastOut"}, 64'(bus.dataOutLast), 64'd0);
    expectEq({pfx, "_dataOut"}, 64'(bus.dataOut), 64'd0);
  endtask

  task automatic startScan(input int fx, input int fy, input int pu, input int pd,
                           input int pl, input int pr, input int lat, input bit inj,
                           input int stallWord);
    int w, h;
    fmX = 11'(fx); fmY = 11'(fy);
    paddingUp = 4'(pu); paddingDown = 4'(pd); paddingLeft = 4'(pl); paddingRight = 4'(pr);
    cfgFmX = fx; cfgFmY = fy; cfgPu = pu; cfgPl = pl;
    memLat = lat; injInv = inj;
    stallAt = stallWord; stallArm = (stallWord >= 0);
    expQ.delete(); rdQ.delete();
    doneCnt = 0; reqCnt = 0; validCnt = 0; wordsRecv = 0; lastCnt = 0; rdSeen = 0;
    w = pl + fx + pr;
    h = pu + fy + pd;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        bit inFm, lst;
        int a;
        inFm = (x >= pl) && (x < pl + fx) && (y >= pu) && (y < pu + fy);
        lst  = (x == w - 1) && (y == h - 1);
        if (inFm && !(inj && x == 1 && y == 1)) begin
          a = 4 + (y - pu) * fx + (x - pl);
          rdQ.push_back('{longint'(a), x, y});
          expQ.push_back('{memWord(longint'(a)), lst});
        end else begin
          expQ.push_back('{16'h0000, lst});
        end
      end
    end
    expWords = expQ.size();
    expReads = rdQ.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishScan(input bit expErr);
    int t;
    for (t = 0; t < 20000; t++) begin
      #1;
      if (doneCnt > 0) break;
      @(negedge clk);
    end
    if (t >= 20000) expectEq("doneTimeout", 64'(doneCnt), 64'd1);
    @(negedge clk);
    #1;
    expectEq("busyAfterDone", 64'(busy), 64'd0);
    expectEq("donePulses", 64'(doneCnt), 64'd1);
    expectEq("wordCount", 64'(wordsRecv), 64'(expWords));
    expectEq("lastCount", 64'(lastCnt), (expWords > 0) ? 64'd1 : 64'd0);
    expectEq("readCount", 64'(rdSeen), 64'(expReads));
    expectEq("wordsLeft", 64'(expQ.size()), 64'd0);
    expectEq("readsLeft", 64'(rdQ.size()), 64'd0);
    expectEq("errFlag", 64'(err), 64'(expErr));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    fmX = '0; fmY = '0;
    paddingUp = '0; paddingDown = '0; paddingLeft = '0; paddingRight = '0;
    repeat (3) @(negedge clk);
    #1 checkIdleOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 5x5 map, padding 2 all round: 81 words, first read at (2,2) addr 4.
    startScan(5, 5, 2, 2, 2, 2, 1, 0, -1);
    #1 expectEq("busyAfterStart", 64'(busy), 64'd1);
    finishScan(0);

    // 3x2 map, no padding, latency 3: six reads 4..9.
    startScan(3, 2, 0, 0, 0, 0, 3, 0, -1);
    finishScan(0);

    // Stall the sink for 10 cycles mid-scan.
    startScan(3, 3, 1, 1, 1, 1, 2, 0, 5);
    finishScan(0);

    // Reset during MEM, then a stale read completion.
    startScan(4, 4, 0, 0, 0, 0, 5, 0, -1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.memRdEn) break;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkIdleOutputs("midReset");
    expQ.delete(); rdQ.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      expectEq("staleBusy", 64'(busy), 64'd0);
      expectEq("staleValid", 64'(bus.dataOutValid), 64'd0);
    end
    expectEq("staleData", 64'(bus.dataOut), 64'd0);
    startScan(4, 3, 1, 0, 2, 1, 2, 0, -1);
    finishScan(0);

    // Empty map: done the cycle after start, no requests, no output.
    startScan(0, 0, 0, 0, 0, 0, 1, 0, -1);
    #1 expectEq("emptyDoneNext", 64'(done), 64'd1);
    finishScan(0);
    expectEq("emptyNoReq", 64'(reqCnt), 64'd0);
    expectEq("emptyNoValid", 64'(validCnt), 64'd0);

    // Invalid answer at (1,1): zero word, sticky err, cleared by next start.
    startScan(3, 3, 1, 1, 1, 1, 1, 1, -1);
    finishScan(1);
    repeat (3) @(negedge clk);
    #1 expectEq("errSticky", 64'(err), 64'd1);
    startScan(2, 2, 0, 0, 0, 0, 1, 0, -1);
    #1 expectEq("errCleared", 64'(err), 64'd0);
    finishScan(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
